// File: rtl/string_hw_pkg.sv
// Shared constants, op codes, FSM states and the control-word helper for the
// string accelerator host master.
package string_hw_pkg;

  localparam int MAX_BLOCKS   = 32'd2;
  localparam int ADDRESS_BITS = 32'd4;

  typedef enum logic [2:0] {
    OP_CMP     = 3'd0,
    OP_UPPER   = 3'd1,
    OP_LOWER   = 3'd2,
    OP_REVERSE = 3'd3
  } op_e;

  localparam int REG_CTRL   = 32'd0;
  localparam int REG_A_BASE = 32'd1;

  localparam int DONE_BIT = 32'd0;
  localparam int GO_BIT   = 32'd1;
  localparam int IDX_LSB  = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_WR_GO  = 3'd3,
    ST_POLL   = 3'd4,
    ST_RD_RES = 3'd5,
    ST_WR_CLR = 3'd6,
    ST_RESP   = 3'd7
  } state_e;

  // Control word layout: go bit plus op index, every other bit written as zero.
  function automatic logic [31:0] ctrl_word(input logic [2:0] op, input logic go);
    logic [31:0] w;
    w = 32'd0;
    w[IDX_LSB +: 3] = op;
    w[GO_BIT] = go;
    return w;
  endfunction

endpackage

// File: rtl/string_hw_host_master_mm_access.sv
// The access engine lives in string_hw_mm_access.sv; this file holds an
// empty compatibility shell module with no ports or logic.
module string_hw_host_master_mm_access;
endmodule

// File: rtl/string_hw_mm_access.sv
// Single Avalon-MM access engine: one strobe cycle, then a gap (write) or
// READ_LATENCY wait cycles (read); done marks the cycle a new start may be issued.
module string_hw_mm_access #(
  parameter int ADDR_W       = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              is_read,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              chipselect,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  logic              busy_r;
  logic              is_rd_r;
  logic              cs_r;
  logic              rd_r;
  logic              wr_r;
  logic [1:0]        lat_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              done_s;

  // Read data is valid exactly in the done cycle, when the master captures it.
  assign done_s = busy_r && !cs_r && (!is_rd_r || (lat_cnt_r == LAT_LAST));

  // Strobe, address hold and latency counting for the access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r    <= 1'b0;
      is_rd_r   <= 1'b0;
      cs_r      <= 1'b0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      lat_cnt_r <= 2'd0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= 32'd0;
    end else if (start) begin
      busy_r    <= 1'b1;
      is_rd_r   <= is_read;
      cs_r      <= 1'b1;
      rd_r      <= is_read;
      wr_r      <= !is_read;
      lat_cnt_r <= 2'd0;
      addr_r    <= addr;
      wdata_r   <= wdata;
    end else if (cs_r) begin
      cs_r <= 1'b0;
      rd_r <= 1'b0;
      wr_r <= 1'b0;
    end else if (done_s) begin
      busy_r <= 1'b0;
    end else if (busy_r) begin
      lat_cnt_r <= lat_cnt_r + 2'd1;
    end
  end

  assign done       = done_s;
  assign rdata      = readdata;
  assign chipselect = cs_r;
  assign read       = rd_r;
  assign write      = wr_r;
  assign address    = addr_r;
  assign writedata  = wdata_r;

endmodule

// File: rtl/string_hw_host_master.sv
// Avalon-MM master sequencing one string-accelerator operation per request.
// Optional poll timeout: define STRING_HW_MASTER_TIMEOUT_EN.
module string_hw_host_master #(
  parameter int MAX_BLOCKS     = string_hw_pkg::MAX_BLOCKS,
  parameter int ADDRESS_BITS   = string_hw_pkg::ADDRESS_BITS,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [MAX_BLOCKS*32-1:0]   req_a,
  input  logic [MAX_BLOCKS*32-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MAX_BLOCKS*32-1:0]   rsp_data,
  output logic                       rsp_timeout,
  output logic                       chipselect,
  output logic                       read,
  output logic                       write,
  output logic [ADDRESS_BITS:0]      address,
  output logic [31:0]                writedata,
  input  logic [31:0]                readdata
);
  import string_hw_pkg::*;

  localparam int AW         = ADDRESS_BITS + 1;
  localparam int IDX_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int REG_B_BASE = REG_A_BASE + MAX_BLOCKS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BLOCKS - 1);

  state_e                     state_r, state_nx;
  logic [IDX_W-1:0]           idx_r, idx_nx;
  logic [2:0]                 op_r;
  logic [MAX_BLOCKS-1:0][31:0] a_r;
  logic [MAX_BLOCKS-1:0][31:0] b_r;
  logic [MAX_BLOCKS-1:0][31:0] rsp_data_r;
  logic                       req_ready_r;
  logic                       rsp_valid_r;

  logic                       accept_s;
  logic                       cap_s;
  logic                       to_s;
  logic                       last_s;
  logic                       poll_limit_s;
  logic                       acc_start_s;
  logic [AW-1:0]              acc_addr_s;
  logic [31:0]                acc_wdata_s;
  logic                       acc_is_read_s;
  logic                       acc_done_s;
  logic [31:0]                acc_rdata_s;

  string_hw_mm_access #(
    .ADDR_W       (AW),
    .READ_LATENCY (READ_LATENCY)
  ) u_access (
    .clk        (clk),
    .reset      (reset),
    .start      (acc_start_s),
    .addr       (acc_addr_s),
    .wdata      (acc_wdata_s),
    .is_read    (acc_is_read_s),
    .done       (acc_done_s),
    .rdata      (acc_rdata_s),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  assign last_s = (idx_r == LAST_IDX);

  // Next state plus the access to launch; a new access always starts in the
  // done cycle of the previous one so the bus never idles between accesses.
  always_comb begin
    state_nx      = state_r;
    idx_nx        = idx_r;
    accept_s      = 1'b0;
    cap_s         = 1'b0;
    to_s          = 1'b0;
    acc_start_s   = 1'b0;
    acc_addr_s    = {AW{1'b0}};
    acc_wdata_s   = 32'd0;
    acc_is_read_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s    = 1'b1;
          acc_start_s = 1'b1;
          acc_addr_s  = AW'(REG_A_BASE);
          acc_wdata_s = req_a[31:0];
          idx_nx      = {IDX_W{1'b0}};
          state_nx    = ST_WR_A;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_A, ST_WR_B: begin
        if (acc_done_s) begin
          acc_start_s = 1'b1;
          if (!last_s) begin
            idx_nx = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            if (state_r == ST_WR_A) begin
              acc_addr_s  = AW'(REG_A_BASE) + AW'(idx_nx);
              acc_wdata_s = a_r[idx_nx];
            end else begin
              acc_addr_s  = AW'(REG_B_BASE) + AW'(idx_nx);
              acc_wdata_s = b_r[idx_nx];
            end
          end else if ((state_r == ST_WR_A) && (op_r == OP_CMP)) begin
            idx_nx      = {IDX_W{1'b0}};
            acc_addr_s  = AW'(REG_B_BASE);
            acc_wdata_s = b_r[0];
            state_nx    = ST_WR_B;
          end else begin
            acc_addr_s  = AW'(REG_CTRL);
            acc_wdata_s = ctrl_word(op_r, 1'b1);
            state_nx    = ST_WR_GO;
          end
        end else begin
          state_nx = state_r;
        end
      end
      ST_WR_GO: begin
        if (acc_done_s) begin
          acc_start_s   = 1'b1;
          acc_is_read_s = 1'b1;
          acc_addr_s    = AW'(REG_CTRL);
          state_nx      = ST_POLL;
        end else begin
          state_nx = ST_WR_GO;
        end
      end
      ST_POLL: begin
        if (!acc_done_s) begin
          state_nx = ST_POLL;
        end else if (acc_rdata_s[DONE_BIT]) begin
          acc_start_s   = 1'b1;
          acc_is_read_s = 1'b1;
          acc_addr_s    = AW'(REG_A_BASE);
          idx_nx        = {IDX_W{1'b0}};
          state_nx      = ST_RD_RES;
        end else if (poll_limit_s) begin
          to_s        = 1'b1;
          acc_start_s = 1'b1;
          acc_addr_s  = AW'(REG_CTRL);
          acc_wdata_s = ctrl_word(op_r, 1'b0);
          state_nx    = ST_WR_CLR;
        end else begin
          acc_start_s   = 1'b1;
          acc_is_read_s = 1'b1;
          acc_addr_s    = AW'(REG_CTRL);
          state_nx      = ST_POLL;
        end
      end
      ST_RD_RES: begin
        if (!acc_done_s) begin
          state_nx = ST_RD_RES;
        end else if (last_s) begin
          cap_s       = 1'b1;
          acc_start_s = 1'b1;
          acc_addr_s  = AW'(REG_CTRL);
          acc_wdata_s = ctrl_word(op_r, 1'b0);
          state_nx    = ST_WR_CLR;
        end else begin
          cap_s         = 1'b1;
          idx_nx        = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          acc_start_s   = 1'b1;
          acc_is_read_s = 1'b1;
          acc_addr_s    = AW'(REG_A_BASE) + AW'(idx_nx);
          state_nx      = ST_RD_RES;
        end
      end
      ST_WR_CLR: begin
        if (acc_done_s) begin
          state_nx = ST_RESP;
        end else begin
          state_nx = ST_WR_CLR;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register, request latch, result capture and registered handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      op_r        <= 3'd0;
      a_r         <= {(MAX_BLOCKS*32){1'b0}};
      b_r         <= {(MAX_BLOCKS*32){1'b0}};
      rsp_data_r  <= {(MAX_BLOCKS*32){1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      idx_r       <= idx_nx;
      req_ready_r <= (state_nx == ST_IDLE);
      rsp_valid_r <= (state_nx == ST_RESP);
      if (accept_s) begin
        op_r       <= req_op;
        a_r        <= req_a;
        b_r        <= req_b;
        rsp_data_r <= {(MAX_BLOCKS*32){1'b0}};
      end else if (cap_s) begin
        rsp_data_r[idx_r] <= acc_rdata_s;
      end
    end
  end

`ifdef STRING_HW_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] poll_cnt_r;
  logic             timeout_r;

  // Limit is checked at each poll's done cycle, so an access is never cut short.
  assign poll_limit_s = (poll_cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));

  // POLL-cycle counter and sticky timeout flag for the current request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_r <= {CNT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      if (state_r == ST_POLL) begin
        poll_cnt_r <= poll_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        poll_cnt_r <= {CNT_W{1'b0}};
      end
      if (accept_s) begin
        timeout_r <= 1'b0;
      end else if (to_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign rsp_timeout = timeout_r;
`else
  logic [32:0] unused_s;

  assign poll_limit_s = 1'b0;
  assign rsp_timeout  = 1'b0;
  assign unused_s     = {to_s, 32'(TIMEOUT_CYCLES)};
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_string_hw_host_master.sv
// Directed bench for string_hw_host_master against a behavioural accelerator
// slave; the timeout scenario runs only with STRING_HW_MASTER_TIMEOUT_EN.
module tb_string_hw_host_master;

`ifdef STRING_HW_MASTER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int n_tests;
  int n_fail;

  string_hw_host_master #(
    .MAX_BLOCKS     (2),
    .ADDRESS_BITS   (4),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .chipselect  (chipselect),
    .read        (read),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  // Behavioural accelerator slave with a configurable number of polls to done.
  logic [31:0] sreg [0:4];
  logic [4:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [63:0] sa, sb, sr;
  logic [7:0]  ch;
  int          poll_cnt;
  int          done_after;
  int          n_polls;
  int          n_res_reads;
  int          proto_err;

  initial begin
    readdata = 32'd0;
    for (int i = 0; i < 5; i++) sreg[i] = 32'd0;
    poll_cnt = 0; done_after = 1; n_polls = 0; n_res_reads = 0; proto_err = 0;
  end

  always @(posedge clk) begin
    if (chipselect && (read == write)) proto_err++;
    if (!chipselect && (read || write)) proto_err++;
    if (chipselect && write) begin
      wr_addr.push_back(address);
      wr_data.push_back(writedata);
      if (address == 5'd0) begin
        if (writedata[1]) begin
          poll_cnt = 0;
          sa = {sreg[2], sreg[1]};
          sb = {sreg[4], sreg[3]};
          sr = sa;
          for (int i = 0; i < 8; i++) begin
            ch = sa[8*i +: 8];
            case (writedata[4:2])
              3'd1: if (ch >= 8'h61 && ch <= 8'h7a) ch = ch - 8'h20;
              3'd2: if (ch >= 8'h41 && ch <= 8'h5a) ch = ch + 8'h20;
              3'd3: ch = sa[8*(7-i) +: 8];
              default: ;
            endcase
            sr[8*i +: 8] = ch;
          end
          if (writedata[4:2] == 3'd0) sr = {sa[63:32], ((sa == sb) ? 32'd1 : 32'd0)};
          sreg[1] = sr[31:0];
          sreg[2] = sr[63:32];
        end
      end else if (address <= 5'd4) begin
        sreg[address] = writedata;
      end
    end
    if (chipselect && read) begin
      if (address == 5'd0) begin
        poll_cnt++;
        n_polls++;
        readdata <= {31'd0, (poll_cnt >= done_after)};
      end else begin
        n_res_reads++;
        readdata <= (address <= 5'd4) ? sreg[address] : 32'd0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] str8(input string s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  int          lat;
  logic        first_wr;
  logic [63:0] got_data;
  logic        got_to;
  logic        stable;

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int polls, input int stall);
    wr_addr.delete();
    wr_data.delete();
    n_polls = 0;
    n_res_reads = 0;
    done_after = polls;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    first_wr = 1'b0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) first_wr = chipselect && write && (address == 5'd1);
      if (rsp_valid) break;
    end
    check_eq("rsp_wait", rsp_valid, 1);
    got_data = rsp_data;
    got_to = rsp_timeout;
    stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== got_data) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_drop", rsp_valid, 0);
    check_eq("ready_after_rsp", req_ready, 1);
  endtask

  logic [31:0] seq;
  int          n_hi;
  logic [31:0] go_val;
  int          k;

  initial begin
    clk = 1'b0; reset = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    req_a = 64'd0; req_b = 64'd0; rsp_ready = 1'b0;
    n_tests = 0; n_fail = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp", {rsp_valid, rsp_timeout}, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_strobes", {chipselect, read, write, address}, 0);
    check_eq("rst_writedata", writedata, 0);
    reset = 1'b0;

    // Compare, equal strings, done on first poll.
    run_op(3'd0, str8("abcdefgh"), str8("abcdefgh"), 1, 0);
    check_eq("cmp_latency", lat, 19);
    check_eq("cmp_first_strobe", first_wr, 1);
    check_eq("cmp_nwrites", wr_addr.size(), 6);
    seq = 32'd0;
    if (wr_addr.size() >= 5) for (int i = 0; i < 5; i++) seq = (seq << 4) | 32'(wr_addr[i]);
    check_eq("cmp_addr_seq", seq, 32'h0001_2340);
    check_eq("cmp_go", (wr_data.size() >= 5) ? wr_data[4] : 32'hdead, 32'h2);
    check_eq("cmp_clr", (wr_addr.size() > 0) ? {wr_addr[$], wr_data[$]} : 37'h1f_ffff_ffff, 37'h0);
    check_eq("cmp_eq_word0", got_data[31:0], 32'd1);
    check_eq("cmp_reads", {n_polls[7:0], n_res_reads[7:0]}, 16'h0102);
    check_eq("cmp_timeout", got_to, 0);

    // Compare, differing strings.
    run_op(3'd0, str8("abcdefgh"), str8("abcdabcd"), 1, 0);
    check_eq("cmp_ne_word0", got_data[31:0], 32'd0);

    // To-upper: B writes skipped, go word carries op 1.
    run_op(3'd1, str8("AbCdEf  "), 64'd0, 1, 0);
    n_hi = 0;
    go_val = 32'hdead;
    foreach (wr_addr[i]) begin
      if (wr_addr[i] == 5'd3 || wr_addr[i] == 5'd4) n_hi++;
      if (wr_addr[i] == 5'd0 && go_val == 32'hdead) go_val = wr_data[i];
    end
    check_eq("upper_no_b", n_hi, 0);
    check_eq("upper_go", go_val, 32'h6);
    check_eq("upper_data", got_data, str8("ABCDEF  "));
    check_eq("upper_latency", lat, 15);

    // Reverse, done after 5 polls, response stalled 3 cycles.
    run_op(3'd3, str8("Hello!  "), 64'd0, 5, 3);
    check_eq("rev_polls", n_polls, 5);
    check_eq("rev_data", got_data, str8("  !olleH"));
    check_eq("rev_stable", stable, 1);

    // Reset while polling, then a fresh to-lower request.
    done_after = 100000;
    @(negedge clk);
    req_op = 3'd3; req_a = str8("Hello!  "); req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (k < 200 && !(chipselect && read && address == 5'd0)) begin
      @(negedge clk);
      k++;
    end
    check_eq("poll_reached", chipselect && read && (address == 5'd0), 1);
    reset = 1'b1;
    #1 check_eq("rst_mid_strobes", {chipselect, read, write}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", req_ready, 1);
    run_op(3'd2, str8("ABCDEFGH"), 64'd0, 1, 0);
    check_eq("lower_data", got_data, str8("abcdefgh"));

`ifdef STRING_HW_MASTER_TIMEOUT_EN
    // Done never set: abort after the poll budget.
    run_op(3'd1, str8("abcdefgh"), 64'd0, 100000, 0);
    check_eq("to_flag", got_to, 1);
    check_eq("to_data", got_data, 64'd0);
    check_eq("to_no_res_reads", n_res_reads, 0);
    check_eq("to_clr", (wr_addr.size() > 0) ? {wr_addr[$], wr_data[$]} : 37'h1f_ffff_ffff, 37'h4);
`endif

    check_eq("protocol", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
